// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 keyboard init handshake, LED command sequencer
// and E0/F0 scan-code decoder between the PS/2 byte PHYs and the app.
module ps2_kbd_ctrl #(
    parameter int F_CLK          = 100_000_000,
    parameter int ACK_TIMEOUT_MS = 20,
    parameter int BAT_TIMEOUT_MS = 1000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic       tx_done,
    input  logic       led_wr,
    input  logic [2:0] led_val,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       kbd_ready,
    output logic       kbd_err
);

    localparam int ACK_CYC = F_CLK / 1000 * ACK_TIMEOUT_MS;
    localparam int BAT_CYC = F_CLK / 1000 * BAT_TIMEOUT_MS;
    localparam int TMR_MAX = (ACK_CYC > BAT_CYC) ? ACK_CYC : BAT_CYC;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0] ACK_LIM   = TW'(ACK_CYC - 1);
    localparam logic [TW-1:0] BAT_LIM   = TW'(BAT_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    localparam logic [7:0] B_RESET   = 8'hFF;
    localparam logic [7:0] B_ACK     = 8'hFA;
    localparam logic [7:0] B_RESEND  = 8'hFE;
    localparam logic [7:0] B_BAT_OK  = 8'hAA;
    localparam logic [7:0] B_BAT_ERR = 8'hFC;
    localparam logic [7:0] B_SETLED  = 8'hED;

    typedef enum logic [3:0] {
        RST_SEND,
        RST_ACK,
        RST_BAT,
        IDLE,
        LED_CMD,
        LED_CMD_ACK,
        LED_ARG,
        LED_ARG_ACK,
        ERROR
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [7:0]      tx_data_nx;
    logic            tx_start_nx;
    logic [TW-1:0]   tmr;
    logic            tmr_run;
    logic            tmo;
    logic [RW-1:0]   retry_cnt;
    logic            retry_inc;
    logic            retry_clr;
    logic            retry_max;
    logic            seq_start;
    logic [2:0]      led_lat;
    logic [2:0]      led_cur;
    logic            led_pend;
    logic            rx_ack;
    logic            rx_rsnd;
    logic            ack_wait;
    logic            dec_en;
    logic            dec_hit;
    logic            pfx_ext;
    logic            pfx_brk;

    assign rx_ack    = rx_ready && (rx_data == B_ACK);
    assign rx_rsnd   = rx_ready && (rx_data == B_RESEND);
    assign retry_max = (retry_cnt == RETRY_LIM);
    assign ack_wait  = (state == RST_ACK) || (state == LED_CMD_ACK) ||
                       (state == LED_ARG_ACK);
    assign tmo       = tmr_run &&
                       (tmr == ((state == RST_BAT) ? BAT_LIM : ACK_LIM));
    assign kbd_ready = (state == IDLE);
    assign kbd_err   = (state == ERROR);

    // State, transmit byte and start pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RST_SEND;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            state    <= state_nx;
            tx_data  <= tx_data_nx;
            tx_start <= tx_start_nx;
        end
    end

    // Next-state logic: send states wait for an idle transmitter,
    // ack states handle ACK, resend and timeout with bounded retries
    always_comb begin
        state_nx    = state;
        tx_data_nx  = tx_data;
        tx_start_nx = 1'b0;
        retry_inc   = 1'b0;
        retry_clr   = 1'b0;
        seq_start   = 1'b0;
        unique case (state)
            RST_SEND: begin
                if (!tx_busy) begin
                    tx_data_nx  = B_RESET;
                    tx_start_nx = 1'b1;
                    state_nx    = RST_ACK;
                end
            end
            RST_ACK: begin
                if (rx_ack) begin
                    retry_clr = 1'b1;
                    state_nx  = RST_BAT;
                end else if (rx_rsnd || tmo) begin
                    if (retry_max) begin
                        state_nx = ERROR;
                    end else begin
                        retry_inc = 1'b1;
                        state_nx  = RST_SEND;
                    end
                end
            end
            RST_BAT: begin
                if (rx_ready && rx_data == B_BAT_OK) begin
                    state_nx = IDLE;
                end else if (rx_ready && rx_data == B_BAT_ERR) begin
                    state_nx = ERROR;
                end else if (tmo) begin
                    if (retry_max) begin
                        state_nx = ERROR;
                    end else begin
                        retry_inc = 1'b1;
                        state_nx  = RST_SEND;
                    end
                end
            end
            IDLE: begin
                if (led_pend || led_wr) begin
                    seq_start = 1'b1;
                    state_nx  = LED_CMD;
                end
            end
            LED_CMD: begin
                if (!tx_busy) begin
                    tx_data_nx  = B_SETLED;
                    tx_start_nx = 1'b1;
                    state_nx    = LED_CMD_ACK;
                end
            end
            LED_CMD_ACK: begin
                if (rx_ack) begin
                    retry_clr = 1'b1;
                    state_nx  = LED_ARG;
                end else if (rx_rsnd || tmo) begin
                    if (retry_max) begin
                        state_nx = ERROR;
                    end else begin
                        retry_inc = 1'b1;
                        state_nx  = LED_CMD;
                    end
                end
            end
            LED_ARG: begin
                if (!tx_busy) begin
                    tx_data_nx  = {5'b0, led_cur};
                    tx_start_nx = 1'b1;
                    state_nx    = LED_ARG_ACK;
                end
            end
            LED_ARG_ACK: begin
                if (rx_ack) begin
                    retry_clr = 1'b1;
                    state_nx  = IDLE;
                end else if (rx_rsnd || tmo) begin
                    if (retry_max) begin
                        state_nx = ERROR;
                    end else begin
                        retry_inc = 1'b1;
                        state_nx  = LED_ARG;
                    end
                end
            end
            ERROR: begin
                state_nx = ERROR;
            end
            default: begin
                state_nx = RST_SEND;
            end
        endcase
    end

    // Response timer: restarts on every state change, runs from tx_done
    // in ack states and from entry in the BAT wait
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr     <= '0;
            tmr_run <= 1'b0;
        end else if (state_nx != state) begin
            tmr     <= '0;
            tmr_run <= (state_nx == RST_BAT);
        end else if (tx_done && ack_wait) begin
            tmr     <= '0;
            tmr_run <= 1'b1;
        end else if (tmr_run) begin
            tmr     <= tmr + TW'(1);
        end
    end

    // Retry counter shared by all send/ack pairs
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (retry_clr) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + RW'(1);
        end
    end

    // LED request latch: newest value wins, one-deep pending flag,
    // value frozen into led_cur when a sequence starts
    always_ff @(posedge clk) begin
        if (rst) begin
            led_lat  <= 3'b000;
            led_cur  <= 3'b000;
            led_pend <= 1'b0;
        end else begin
            if (led_wr) begin
                led_lat <= led_val;
            end
            if (seq_start) begin
                led_cur  <= led_wr ? led_val : led_lat;
                led_pend <= 1'b0;
            end else if (led_wr && state != IDLE) begin
                led_pend <= 1'b1;
            end
        end
    end

    assign dec_en  = (state == IDLE) || (state == LED_CMD) ||
                     (state == LED_CMD_ACK) || (state == LED_ARG) ||
                     (state == LED_ARG_ACK);
    assign dec_hit = rx_ready && dec_en &&
                     !((state == LED_CMD_ACK || state == LED_ARG_ACK) &&
                       (rx_data == B_ACK || rx_data == B_RESEND));

    // Scan-code decoder: prefixes set flags, a code byte emits one event
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            key_valid <= 1'b0;
            pfx_ext   <= 1'b0;
            pfx_brk   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (dec_hit) begin
                case (rx_data)
                    8'hE0, 8'hE1: pfx_ext <= 1'b1;
                    8'hF0:        pfx_brk <= 1'b1;
                    8'h00, 8'hFF: begin
                        pfx_ext <= 1'b0;
                        pfx_brk <= 1'b0;
                    end
                    default: begin
                        key_code  <= rx_data;
                        key_ext   <= pfx_ext;
                        key_break <= pfx_brk;
                        key_valid <= 1'b1;
                        pfx_ext   <= 1'b0;
                        pfx_brk   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
